// File: rtl/gray_counter_pkg.sv
// rtl/gray_counter_pkg.sv - shared width default and Gray code helpers
package gray_counter_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    // Operates at the maximum width; callers zero-extend and truncate to their own width.
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] gray);
        logic [GRAY_WIDTH_MAX-1:0] bin;
        bin[GRAY_WIDTH_MAX-1] = gray[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/converter_g.sv
// rtl/converter_g.sv - combinational binary-to-Gray mapping
module converter_g
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    logic [GRAY_WIDTH_MAX-1:0] g_full;

    always_comb begin
        g_full = bin2gray(GRAY_WIDTH_MAX'(b));
        g      = g_full[WIDTH-1:0];
    end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered, cycle-aligned Gray output
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        if (load) begin
            b_d = load_b;
        end else if (en) begin
            if (up_dn) begin
                b_d    = b_q + ONE;
                wrap_d = (b_q == ALL_ONES);
            end else begin
                b_d    = b_q - ONE;
                wrap_d = (b_q == '0);
            end
        end
    end

    // Gray is derived from the next binary value so both registers update on the same edge.
    converter_g #(.WIDTH(WIDTH)) u_converter_g (
        .b (b_d),
        .g (g_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q    <= '0;
            g_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign b    = b_q;
    assign g    = g_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed vector table plus constrained random run for gray_counter
module tb_gray_counter;

    localparam int W = 4;

    typedef struct {
        logic         rst;
        logic         en;
        logic         up_dn;
        logic         load;
        logic [W-1:0] load_b;
        logic [W-1:0] exp_b;
        logic [W-1:0] exp_g;
        logic         exp_wrap;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load;
    logic [W-1:0] load_b;
    logic [W-1:0] b, g;
    logic         wrap;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    gray_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .up_dn  (up_dn),
        .load   (load),
        .load_b (load_b),
        .b      (b),
        .g      (g),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb, input logic [W-1:0] eb,
                       input logic [W-1:0] eg, input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.load = l; v.load_b = lb;
        v.exp_b = eb; v.exp_g = eg; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [W-1:0] lb);
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; load_b = lb;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] tb_gray2bin(input logic [W-1:0] gv);
        logic [W-1:0] r;
        r[W-1] = gv[W-1];
        for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
        return r;
    endfunction

    initial begin
        logic [W-1:0] up_g[16];
        logic [W-1:0] m_b, prev_g;
        logic         m_wrap, stepped;
        logic         r_rst, r_en, r_up, r_load;
        logic [W-1:0] r_lb;

        rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_b = '0;

        up_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        // Reset, then a full up cycle that wraps on the last step
        add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 16; i++)
            add(0, 1, 1, 0, 4'h0, W'(i + 1), up_g[i], (i == 15));
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
        // Load of current value, then down-wrap and hold
        add(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1);
        add(0, 0, 0, 0, 4'h0, 4'hF, 4'b1000, 0);
        // Load wins over en
        add(0, 1, 1, 1, 4'b0101, 4'b0101, 4'b0111, 0);
        add(0, 1, 0, 1, 4'b0101, 4'b0101, 4'b0111, 0);
        add(0, 1, 1, 0, 4'h0, 4'b0110, 4'b0101, 0);
        // Reset overrides load and en mid-count
        add(1, 1, 1, 1, 4'b1010, 4'h0, 4'h0, 0);
        add(0, 1, 1, 0, 4'h0, 4'b0001, 4'b0001, 0);
        // Direction alternation from 0011
        add(0, 0, 0, 1, 4'b0011, 4'b0011, 4'b0010, 0);
        add(0, 1, 1, 0, 4'h0, 4'b0100, 4'b0110, 0);
        add(0, 1, 0, 0, 4'h0, 4'b0011, 4'b0010, 0);
        add(0, 1, 1, 0, 4'h0, 4'b0100, 4'b0110, 0);
        add(0, 1, 0, 0, 4'h0, 4'b0011, 4'b0010, 0);
        add(0, 1, 0, 0, 4'h0, 4'b0010, 4'b0011, 0);
        add(0, 0, 1, 0, 4'h0, 4'b0010, 4'b0011, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_b);
            chk($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_g", i), 32'(g), 32'(vecs[i].exp_g));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // Random run against an arithmetic scoreboard
        m_b = b;
        for (int c = 0; c < 1000; c++) begin
            r_rst  = ($urandom_range(0, 49) == 0);
            r_load = ($urandom_range(0, 9) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_up   = 1'($urandom_range(0, 1));
            r_lb   = W'($urandom_range(0, 15));
            prev_g = g;
            stepped = 1'b0;
            m_wrap = 1'b0;
            if (r_rst) begin
                m_b = '0;
            end else if (r_load) begin
                m_b = r_lb;
            end else if (r_en) begin
                stepped = 1'b1;
                if (r_up) begin
                    m_wrap = (m_b == 4'hF);
                    m_b = m_b + 4'd1;
                end else begin
                    m_wrap = (m_b == 4'h0);
                    m_b = m_b - 4'd1;
                end
            end
            drive(r_rst, r_en, r_up, r_load, r_lb);
            chk("rand_b", 32'(b), 32'(m_b));
            chk("rand_wrap", 32'(wrap), 32'(m_wrap));
            chk("rand_gray_map", 32'(g), 32'(m_b ^ (m_b >> 1)));
            chk("rand_g2b", 32'(tb_gray2bin(g)), 32'(m_b));
            if (stepped)
                chk("rand_one_bit", 32'($countones(g ^ prev_g)), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  count enable; one step per cycle while high.
REQ-005 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 load  input  1  load request; takes priority over en.
REQ-007 load_b  input  WIDTH  binary value loaded when load is high.
REQ-008 b  output  WIDTH  registered binary count.
REQ-009 g  output  WIDTH  registered Gray code of b, cycle-aligned with b.
REQ-010 wrap  output  1  registered one-cycle pulse on modulo wrap-around.

Function
REQ-011 The Gray mapping SHALL be g = b XOR (b >> 1), bitwise, WIDTH bits, no sign extension.
REQ-012 g SHALL be computed from the next binary value and registered in the same edge as b; no cycle where g and b disagree.
REQ-013 Latency: a control input sampled at edge N SHALL be reflected on b, g and wrap after edge N.
REQ-014 Priority per cycle: rst > load > en > hold.
REQ-015 load high: b <= load_b, g <= Gray(load_b), wrap <= 0, regardless of en and up_dn.
REQ-016 en high, load low, up_dn 1: b <= b + 1 modulo 2^WIDTH.
REQ-017 en high, load low, up_dn 0: b <= b - 1 modulo 2^WIDTH.
REQ-018 en low, load low: b and g SHALL hold; wrap <= 0.
REQ-019 wrap SHALL be 1 for exactly one cycle after an up step from 2^WIDTH-1 to 0 or a down step from 0 to 2^WIDTH-1; 0 otherwise.
REQ-020 Consecutive counting steps SHALL change exactly one bit of g, including across wrap-around.
REQ-021 A direction change between consecutive enabled cycles SHALL take effect immediately with no dead cycle.
REQ-022 load of the current value SHALL leave b and g unchanged and SHALL not assert wrap.

Reset
REQ-023 rst high at an edge SHALL set b = 0, g = 0, wrap = 0, overriding load and en.
REQ-024 rst asserted mid-count SHALL abandon the count; the first enabled cycle after rst deasserts SHALL step from 0.
REQ-025 No output SHALL be X after the first edge with rst high.

Structure
REQ-026 A shared package SHALL hold the WIDTH default and a bin-to-Gray function reusable by the Gray-to-binary converter bench.
REQ-027 The combinational bin-to-Gray mapping SHALL be one sub-module, converter_g, inverse of the existing Gray-to-binary converter.
REQ-028 gray_counter SHALL hold only the binary register, the Gray register, the wrap register and next-state logic.

Verification
REQ-029 Reset then 16 cycles en=1, up_dn=1 -> g sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only after the last step.
REQ-030 load=1, load_b=0000, then en=1, up_dn=0 for one cycle -> b=1111, g=1000, wrap=1 for one cycle.
REQ-031 en=1 and load=1, load_b=0101, same cycle -> b=0101, g=0111, wrap=0 (load wins).
REQ-032 Count up to b=0110, then rst=1 for one cycle with en=1 -> b=0000, g=0000, wrap=0; next enabled up step -> g=0001.
REQ-033 Alternate up_dn 1,0,1,0 with en=1 from b=0011 -> b sequence 0100,0011,0100,0011; g toggles 0110/0010.
REQ-034 Random en/up_dn/load for 1000 cycles -> g == b XOR (b>>1) every cycle; every enabled step changes exactly one bit of g; result matches Gray-to-binary converter applied to g.
